hilo_divider: RTL
=================

Name: hilo_divider

Overview:
- Multi-cycle integer divider for the execute stage; executes DIV, DIVU, DDIV and DDIVU.
- Quotient goes to LO and remainder to HI; these are the values read back by MFLO and MFHI.
- It is the inverse-operation companion of the ALU's multicycle multiplier and shares its go/busy handshake with the pipeline.
- It also owns the MTLO and MTHI writes into its LO/HI registers.
- Iterative radix-2 non-restoring/restoring core, one quotient bit per phi2-qualified clock.

Parameters:
- none; widths are fixed by the ISA (64-bit GPRs).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- phi2  in  1  clock enable; all state advances only on clk edges with phi2=1
- go  in  1  start request; sampled in IDLE only
- dword  in  1  1 = 64-bit op (DDIV/DDIVU), 0 = 32-bit op
- sgn  in  1  1 = signed op
- dividend  in  64  rs operand
- divisor  in  64  rt operand
- wrlo  in  1  MTLO strobe
- wrhi  in  1  MTHI strobe
- wdata  in  64  MTLO/MTHI data
- busy  out  1  high while a division is in progress (registered)
- done  out  1  one phi2-period pulse after results land
- lo  out  64  LO register
- hi  out  64  HI register

Behaviour:
Reset:
- rstn=0 forces state=IDLE, busy=0, done=0, lo=0, hi=0, counter=0, asynchronously.
- Reset mid-division discards the operation; no partial result is written.

States and transitions (all on clk with phi2=1):
- IDLE:
  - go=1 latches operands, dword and sgn, then moves to PREP.
  - For 32-bit ops only bits [31:0] of each operand are used; the upper bits are ignored.
- PREP:
  - Record the quotient sign (sgn and sign(dividend) xor sign(divisor)) and the remainder sign (sgn and sign(dividend)).
  - Load magnitudes: for signed ops take the absolute value; for unsigned ops take the raw value.
  - Load the iteration counter with 31 (32-bit) or 63 (64-bit).
  - Record divisor-zero.
  - Move to ITER.
- ITER:
  - Each cycle: shift one dividend bit into the 65-bit partial remainder, trial-subtract the divisor, set the quotient bit.
  - Decrement the counter; when it reaches 0, move to FIX.
- FIX:
  - Negate quotient and remainder according to the recorded signs.
  - For 32-bit ops, sign-extend bit 31 of each result into [63:32].
  - Write lo and hi, then move to IDLE.

Handshake and latency:
- busy=1 in PREP, ITER and FIX.
- busy is high for 34 phi2 cycles (32-bit) or 66 phi2 cycles (64-bit).
- done=1 during the first IDLE phi2 period after FIX, then returns to 0.
- go while busy is ignored.
- Results are stable on lo/hi from the same edge on which done rises.

Divide by zero:
- No exception is raised; the op takes the full latency.
- Unsigned: lo = all-ones (after 32-bit sign extension); hi = dividend.
- Signed: lo = +1 if the dividend is negative, otherwise -1; hi = dividend.
- For 32-bit ops both results are sign-extended from bit 31.

Signed overflow:
- -2^31 / -1 (32-bit) gives lo=0xFFFFFFFF80000000, hi=0.
- -2^63 / -1 (64-bit) gives lo=0x8000000000000000, hi=0.
- Both cases fall out of the magnitude algorithm; no special case is needed.

MTLO/MTHI:
- wrlo/wrhi in IDLE write wdata into lo/hi (both may fire in the same cycle).
- Writes while busy are ignored.
- go together with wrlo/wrhi in the same cycle: go wins and the write is dropped.

Sign conventions:
- Remainder sign follows the dividend.
- Quotient truncates toward zero.

Test Plan:
- DIVU 100/7 (dword=0, sgn=0) -> busy high 34 phi2 cycles, then done pulse, lo=0x000000000000000E, hi=0x0000000000000002.
- DIV -7/2 (dividend=0xFFFFFFFFFFFFFFF9, divisor=2) -> lo=0xFFFFFFFFFFFFFFFD, hi=0xFFFFFFFFFFFFFFFF.
- DDIVU 0xFFFFFFFFFFFFFFFF/0x10 -> busy 66 cycles, lo=0x0FFFFFFFFFFFFFFF, hi=0x000000000000000F.
- DIV 0x80000000/0xFFFFFFFF with upper operand bits set to garbage -> lo=0xFFFFFFFF80000000, hi=0.
- Divide by zero:
  - DIVU 5/0 -> lo=0xFFFFFFFFFFFFFFFF, hi=5.
  - DIV -5/0 -> lo=1, hi=0xFFFFFFFFFFFFFFFB.
- Control:
  - MTLO 0x1234 in IDLE -> lo=0x1234.
  - Second go and wrhi at cycle 10 of a division -> both ignored.
  - rstn pulsed low at ITER cycle 20 -> busy=0, lo=hi=0 immediately, no done pulse.

Source files
------------

// File: rtl/hilo_divider.sv
// Iterative radix-2 restoring divider owning the LO/HI registers.
// Handles DIV/DIVU/DDIV/DDIVU plus MTLO/MTHI writes, one quotient bit per phi2 cycle.
module hilo_divider (
   input  logic        clk,
   input  logic        rstn,
   input  logic        phi2,
   input  logic        go,
   input  logic        dword,
   input  logic        sgn,
   input  logic [63:0] dividend,
   input  logic [63:0] divisor,
   input  logic        wrlo,
   input  logic        wrhi,
   input  logic [63:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [63:0] lo,
   output logic [63:0] hi
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_ITER = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_busy;
   logic        r_done;
   logic [5:0]  r_cnt;
   logic [63:0] r_a;
   logic [63:0] r_b;
   logic        r_dword;
   logic        r_sgn;
   logic        r_qneg;
   logic        r_rneg;
   logic        r_dvz;
   logic [64:0] r_rem;
   logic [63:0] r_quo;
   logic [63:0] r_dvs;
   logic [63:0] r_lo;
   logic [63:0] r_hi;

   logic        w_a_neg;
   logic        w_b_neg;
   logic [63:0] w_a_mag;
   logic [63:0] w_b_mag;
   logic [65:0] w_shift;
   logic [65:0] w_diff;
   logic        w_q_bit;
   logic [63:0] w_q_fix;
   logic [63:0] w_r_fix;
   logic [63:0] w_lo_res;
   logic [63:0] w_hi_res;

   // Magnitude of an operand at the active width; 32-bit ops ignore bits [63:32].
   function automatic logic [63:0] f_mag(input logic [63:0] v, input logic dw, input logic sg);
      logic [63:0] m;
      if (dw) begin
         if (sg && v[63]) m = 64'd0 - v;
         else             m = v;
      end else begin
         if (sg && v[31]) m = {32'd0, 32'd0 - v[31:0]};
         else             m = {32'd0, v[31:0]};
      end
      return m;
   endfunction

   // 32-bit results are architecturally sign-extended from bit 31.
   function automatic logic [63:0] f_sext(input logic [63:0] v, input logic dw);
      logic [63:0] s;
      if (dw) s = v;
      else    s = {{32{v[31]}}, v[31:0]};
      return s;
   endfunction

   // Operand preparation, trial subtraction and result fix-up.
   always_comb begin
      w_a_neg  = r_dword ? r_a[63] : r_a[31];
      w_b_neg  = r_dword ? r_b[63] : r_b[31];
      w_a_mag  = f_mag(r_a, r_dword, r_sgn);
      w_b_mag  = f_mag(r_b, r_dword, r_sgn);
      w_shift  = {r_rem, r_quo[63]};
      w_diff   = w_shift - {2'b00, r_dvs};
      w_q_bit  = ~w_diff[65];
      w_q_fix  = r_qneg ? (64'd0 - r_quo) : r_quo;
      w_r_fix  = r_rneg ? (64'd0 - r_rem[63:0]) : r_rem[63:0];
      w_lo_res = f_sext(w_q_fix, r_dword);
      if (r_dvz) begin
         w_hi_res = f_sext(r_a, r_dword);
      end else begin
         w_hi_res = f_sext(w_r_fix, r_dword);
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (go) w_state_nxt = ST_PREP;
            else    w_state_nxt = ST_IDLE;
         end
         ST_PREP: w_state_nxt = ST_ITER;
         ST_ITER: begin
            if (r_cnt == 6'd0) w_state_nxt = ST_FIX;
            else               w_state_nxt = ST_ITER;
         end
         ST_FIX:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register with registered busy and single-period done.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (phi2) begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_done  <= (r_state == ST_FIX);
      end
   end

   // Datapath: operand latch, iteration, result write-back and MTLO/MTHI.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt   <= 6'd0;
         r_a     <= 64'd0;
         r_b     <= 64'd0;
         r_dword <= 1'b0;
         r_sgn   <= 1'b0;
         r_qneg  <= 1'b0;
         r_rneg  <= 1'b0;
         r_dvz   <= 1'b0;
         r_rem   <= 65'd0;
         r_quo   <= 64'd0;
         r_dvs   <= 64'd0;
         r_lo    <= 64'd0;
         r_hi    <= 64'd0;
      end else if (phi2) begin
         case (r_state)
            ST_IDLE: begin
               if (go) begin
                  r_a     <= dividend;
                  r_b     <= divisor;
                  r_dword <= dword;
                  r_sgn   <= sgn;
               end else begin
                  if (wrlo) r_lo <= wdata;
                  if (wrhi) r_hi <= wdata;
               end
            end
            ST_PREP: begin
               r_qneg <= r_sgn & (w_a_neg ^ w_b_neg);
               r_rneg <= r_sgn & w_a_neg;
               r_dvs  <= w_b_mag;
               r_dvz  <= (w_b_mag == 64'd0);
               r_rem  <= 65'd0;
               // 32-bit dividends are left-aligned so bit 63 always feeds the remainder.
               r_quo  <= r_dword ? w_a_mag : {w_a_mag[31:0], 32'd0};
               r_cnt  <= r_dword ? 6'd63 : 6'd31;
            end
            ST_ITER: begin
               if (w_q_bit) r_rem <= w_diff[64:0];
               else         r_rem <= w_shift[64:0];
               r_quo <= {r_quo[62:0], w_q_bit};
               r_cnt <= r_cnt - 6'd1;
            end
            ST_FIX: begin
               r_lo <= w_lo_res;
               r_hi <= w_hi_res;
            end
            default: begin
               r_cnt <= 6'd0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign lo   = r_lo;
   assign hi   = r_hi;

endmodule
